// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory block responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } dmem_state_t;

    localparam int unsigned BLOCK_BITS      = 128;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    // Returned for reads that fall outside the populated array
    localparam logic [BLOCK_BITS-1:0] DMEM_POISON =
        {WORDS_PER_BLOCK{WORD_BITS'(32'hDEAD_BEEF)}};

endpackage

// File: rtl/dmem_array.sv
// Block store: MEM_DEPTH x 128-bit, synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned IdxW     = $clog2(MEM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [IdxW-1:0]       i_waddr,
    input  logic [BLOCK_BITS-1:0] i_wdata,
    input  logic [IdxW-1:0]       i_raddr,
    output logic [BLOCK_BITS-1:0] o_rdata
);

    logic [BLOCK_BITS-1:0] r_mem [MEM_DEPTH];

    // Commit a whole block on the write-enable edge
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_memory.sv
// Main-memory responder for data-cache refill / write-back of 128-bit blocks.
// Optional feature macro: DATA_MEM_ERR_EN adds mem_error, range checking and poison reads.
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 28,
    parameter int unsigned MEM_DEPTH     = 256,
    parameter int unsigned READ_LATENCY  = 5,
    parameter int unsigned WRITE_LATENCY = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [BLOCK_BITS-1:0] mem_writedata,
    output logic [BLOCK_BITS-1:0] mem_readdata,
    output logic                  mem_busywait
`ifdef DATA_MEM_ERR_EN
    ,
    output logic                  mem_error
`endif
);

    localparam int unsigned IdxW   = $clog2(MEM_DEPTH);
    localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);
    // The request cycle counts toward the latency, so READ/WRITE last LATENCY-1 cycles
    localparam logic [CntW-1:0] RdLoad = CntW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [CntW-1:0] WrLoad = CntW'((WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0);

    dmem_state_t           r_state;
    logic [CntW-1:0]       r_count;
    logic [IdxW-1:0]       r_addr;
    logic [BLOCK_BITS-1:0] r_data;
    logic [BLOCK_BITS-1:0] r_readdata;

    logic                  w_idle;
    logic                  w_accept_rd;
    logic                  w_accept_wr;
    logic                  w_do_read;
    logic                  w_do_write;
    logic                  w_oor;
    logic [IdxW-1:0]       w_idx;
    logic [BLOCK_BITS-1:0] w_wdata;
    logic [BLOCK_BITS-1:0] w_rdata;

    assign w_idle      = (r_state == IDLE);
    assign w_accept_wr = w_idle & mem_write;
    assign w_accept_rd = w_idle & ~mem_write & mem_read;

    // A 1-cycle latency completes on the accept edge itself, using the live request
    assign w_do_read  = ((r_state == READ) && (r_count == '0)) ||
                        (w_accept_rd && (READ_LATENCY == 1));
    assign w_do_write = ((r_state == WRITE) && (r_count == '0)) ||
                        (w_accept_wr && (WRITE_LATENCY == 1));

    assign w_idx   = w_idle ? mem_address[IdxW-1:0] : r_addr;
    assign w_wdata = w_idle ? mem_writedata : r_data;

`ifdef DATA_MEM_ERR_EN
    logic r_oor;
    logic r_both;
    logic r_error;
    logic w_in_oor;
    logic w_bad;

    assign w_in_oor  = {1'b0, mem_address} >= (ADDR_WIDTH + 1)'(MEM_DEPTH);
    assign w_oor     = w_idle ? w_in_oor : r_oor;
    assign w_bad     = w_oor | (w_idle ? (mem_read & mem_write) : r_both);
    assign mem_error = r_error;
`else
    logic w_unused;

    // Upper address bits are ignored: the block address wraps modulo MEM_DEPTH
    assign w_oor    = 1'b0;
    assign w_unused = ^mem_address;
`endif

    dmem_array #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_array (
        .i_clk  (clk),
        .i_we   (w_do_write & ~w_oor),
        .i_waddr(w_idx),
        .i_wdata(w_wdata),
        .i_raddr(w_idx),
        .o_rdata(w_rdata)
    );

    // Transfer FSM: accept in IDLE, count down in READ/WRITE, one ACK cycle, back to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_readdata <= '0;
`ifdef DATA_MEM_ERR_EN
            r_oor      <= 1'b0;
            r_both     <= 1'b0;
            r_error    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_addr  <= mem_address[IdxW-1:0];
`ifdef DATA_MEM_ERR_EN
                        r_oor   <= w_in_oor;
                        r_both  <= mem_read & mem_write;
                        r_error <= 1'b0;
`endif
                    end
                    if (mem_write) begin
                        r_data  <= mem_writedata;
                        r_count <= WrLoad;
                        r_state <= (WRITE_LATENCY == 1) ? ACK : WRITE;
                    end else if (mem_read) begin
                        r_count <= RdLoad;
                        r_state <= (READ_LATENCY == 1) ? ACK : READ;
                    end
                end
                READ, WRITE: begin
                    if (r_count == '0) begin
                        r_state <= ACK;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_do_read) begin
                r_readdata <= w_oor ? DMEM_POISON : w_rdata;
            end
`ifdef DATA_MEM_ERR_EN
            // Placed after the accept clear so a 1-cycle transfer still flags its error
            if (w_do_read || w_do_write) begin
                r_error <= w_bad;
            end
`endif
        end
    end

    // Stall the cache from the request cycle until ACK
    always_comb begin
        mem_busywait = 1'b1;
        if (r_state == IDLE) begin
            mem_busywait = mem_read | mem_write;
        end else if (r_state == ACK) begin
            mem_busywait = 1'b0;
        end
    end

    assign mem_readdata = r_readdata;

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory with a transfer-level reference model.
// Build with DATA_MEM_ERR_EN defined to exercise the error/poison feature.
module tb_data_memory;
    import dmem_pkg::*;

    localparam int unsigned AW    = 28;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned RL    = 5;
    localparam int unsigned WL    = 5;
`ifdef DATA_MEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [127:0]  mem_writedata;
    logic [127:0]  mem_readdata;
    logic          mem_busywait;
    logic          mem_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_memory #(
        .ADDR_WIDTH   (AW),
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
`ifdef DATA_MEM_ERR_EN
        ,
        .mem_error    (mem_error)
`endif
    );

`ifndef DATA_MEM_ERR_EN
    assign mem_error = 1'b0;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model: one transfer at a time, cycle index k ----------------
    logic [127:0]  m_mem [DEPTH];
    logic [127:0]  m_rd   = '0;
    logic [127:0]  m_data;
    logic [AW-1:0] m_addr;
    bit            m_xfer = 1'b0;
    bit            m_wr, m_bad, m_oor;
    bit            m_err  = 1'b0;
    int            m_k, m_lat, m_idx;

    always @(negedge clk) begin
        if (!rst) begin
            m_xfer = 1'b0;
            m_rd   = '0;
            m_err  = 1'b0;
            check("cmp reset busywait", 128'(mem_busywait), 128'(mem_read | mem_write));
            check("cmp reset readdata", mem_readdata, '0);
`ifdef DATA_MEM_ERR_EN
            check("cmp reset error", 128'(mem_error), 128'(0));
`endif
        end else begin
            if (!m_xfer && (mem_read || mem_write)) begin
                m_xfer = 1'b1;
                m_k    = 0;
                m_wr   = mem_write;
                m_addr = mem_address;
                m_data = mem_writedata;
                m_lat  = mem_write ? WL : RL;
                m_idx  = int'(mem_address % DEPTH);
                m_oor  = ERR && (mem_address >= DEPTH);
                m_bad  = ERR && (m_oor || (mem_read && mem_write));
            end
            check("cmp busywait", 128'(mem_busywait), 128'(m_xfer && (m_k < m_lat)));
            check("cmp readdata", mem_readdata, m_rd);
`ifdef DATA_MEM_ERR_EN
            check("cmp error", 128'(mem_error), 128'(m_err));
`endif
            if (m_xfer) begin
                if (m_k == 0) m_err = 1'b0;
                if (m_k == m_lat - 1) begin
                    if (m_wr) begin
                        if (!m_oor) m_mem[m_idx] = m_data;
                    end else begin
                        m_rd = m_oor ? DMEM_POISON : m_mem[m_idx];
                    end
                    m_err = m_bad;
                end
                if (m_k == m_lat) m_xfer = 1'b0;
                m_k++;
            end
        end
    end

    // ---------------- cache-side driver ----------------
    task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [127:0] d, input bit keep, input bit scramble,
                        output int nbusy, output logic [127:0] rdat, output logic err);
        int cyc  = 0;
        bit done = 1'b0;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
        nbusy = 0;
        rdat  = 'x;
        err   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (mem_busywait) begin
                nbusy++;
            end else begin
                done = 1'b1;
                rdat = mem_readdata;
                err  = mem_error;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (done && !keep) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end else if (!done && scramble) begin
                mem_address   = AW'($urandom);
                mem_writedata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!done && cyc > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer timeout: busywait still 1 after %0d cycles, required 0", cyc);
                mem_read  = 1'b0;
                mem_write = 1'b0;
                done      = 1'b1;
            end
        end
    endtask

    initial begin
        int           nb, nb2;
        logic [127:0] rd;
        logic         er;
        logic [31:0]  w;
        logic [127:0] l1, l5, l6;

        l1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        l5 = 128'h5555_0000_5555_1111_5555_2222_5555_3333;
        l6 = 128'h6666_CAFE_6666_F00D_6666_BEEF_6666_0BAD;

        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_writedata = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busywait", 128'(mem_busywait), 128'(0));
        check("reset readdata", mem_readdata, '0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Populate the whole array so every later read has a known value
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
            xfer(1'b0, 1'b1, AW'(i), {w, ~w, w, ~w}, 1'b0, 1'b0, nb, rd, er);
        end

        // 1: read of a known block, 5 busy cycles then ACK
        xfer(1'b0, 1'b1, AW'(3), l1, 1'b0, 1'b0, nb, rd, er);
        xfer(1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, nb, rd, er);
        check("t1 read busy cycles", 128'(nb), 128'(5));
        check("t1 read data", rd, l1);

        // 2: write then read back
        xfer(1'b0, 1'b1, AW'(10), {4{32'hAAAA_AAAA}}, 1'b0, 1'b0, nb, rd, er);
        check("t2 write busy cycles", 128'(nb), 128'(5));
        xfer(1'b1, 1'b0, AW'(10), '0, 1'b0, 1'b0, nb, rd, er);
        check("t2 read data", rd, {4{32'hAAAA_AAAA}});

        // 3: request held through ACK starts a second transfer immediately
        xfer(1'b1, 1'b0, AW'(3), '0, 1'b1, 1'b0, nb, rd, er);
        xfer(1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b0, nb2, rd, er);
        check("t3 first busy cycles", 128'(nb), 128'(5));
        check("t3 second busy cycles", 128'(nb2), 128'(5));
        check("t3 second data", rd, l1);

        // 4: reset in cycle 3 of a write to addr 7 aborts it
        xfer(1'b0, 1'b1, AW'(7), '0, 1'b0, 1'b0, nb, rd, er);
        mem_write = 1'b1;
        mem_address = AW'(7);
        mem_writedata = '1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("t4 busy with request held", 128'(mem_busywait), 128'(1));
        @(posedge clk);
        #1 mem_write = 1'b0;
        @(negedge clk);
        check("t4 busy after drop", 128'(mem_busywait), 128'(0));
        check("t4 readdata in reset", mem_readdata, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        xfer(1'b1, 1'b0, AW'(7), '0, 1'b0, 1'b0, nb, rd, er);
        check("t4 addr7 not committed", rd, '0);

        // 5: out-of-range block address
        xfer(1'b0, 1'b1, AW'(5), l5, 1'b0, 1'b0, nb, rd, er);
        xfer(1'b1, 1'b0, AW'(DEPTH + 5), '0, 1'b0, 1'b0, nb, rd, er);
        check("t5 wrap/poison data", rd, ERR ? DMEM_POISON : l5);
        check("t5 error flag", 128'(er), 128'(ERR));
        xfer(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, nb, rd, er);
        check("t5 in-range data", rd, l5);
        check("t5 in-range error clear", 128'(er), 128'(0));

        // 6: read and write together, write wins and readdata holds
        xfer(1'b0, 1'b1, AW'(2), l6, 1'b0, 1'b0, nb, rd, er);
        xfer(1'b1, 1'b0, AW'(2), '0, 1'b0, 1'b0, nb, rd, er);
        xfer(1'b1, 1'b1, AW'(2), 128'h1, 1'b0, 1'b0, nb, rd, er);
        check("t6 readdata unchanged", rd, l6);
        check("t6 error flag", 128'(er), 128'(ERR));
        check("t6 both busy cycles", 128'(nb), 128'(WL));
        xfer(1'b1, 1'b0, AW'(2), '0, 1'b0, 1'b0, nb, rd, er);
        check("t6 write performed", rd, 128'h1);

        // Random traffic, checked every cycle by the model
        for (int t = 0; t < 400; t++) begin
            int unsigned op;
            logic [AW-1:0] a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 9) < 8) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom);
            xfer(op < 5 || op == 9, op >= 5, a, {$urandom, $urandom, $urandom, $urandom},
                 1'b0, $urandom_range(0, 1) == 1, nb, rd, er);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
